// File: rtl/seq_lr_shifter.sv
// Iterative shifter: moves a loaded word one bit per clock, left or right,
// logical or rotate, and pulses done when the requested count is used up.
module seq_lr_shifter #(
   parameter int N     = 3,
   parameter int Width = 2 ** N
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [Width-1:0] a,
   input  logic [N-1:0]     amt,
   input  logic             dir,
   input  logic             rot,
   output logic             busy,
   output logic             done,
   output logic [Width-1:0] y,
   output logic [1:0]       state_dbg
);

   // Handshake: start is taken only when busy=0 (IDLE); operands are captured on
   // that edge. done is high for exactly one cycle and y is valid in that cycle.
   // start while busy=1 is dropped, not queued.
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t           state, state_next;
   logic [N-1:0]     count;
   logic             dir_q, rot_q;
   logic             load, step;
   logic [Width-1:0] shifted;

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
         count <= '0;
         y     <= '0;
         dir_q <= 1'b0;
         rot_q <= 1'b0;
      end else begin
         state <= state_next;
         if (load) begin
            y     <= a;
            count <= amt;
            dir_q <= dir;
            rot_q <= rot;
         end else if (step) begin
            y     <= shifted;
            count <= count - N'(1);
         end
      end
   end

   // Fill bit is the wrapped-around bit in rotate mode, zero otherwise.
   always_comb begin
      shifted = y;
      if (dir_q)
         shifted = {y[Width-2:0], rot_q ? y[Width-1] : 1'b0};
      else
         shifted = {rot_q ? y[0] : 1'b0, y[Width-1:1]};
   end

   always_comb begin
      state_next = state;
      load       = 1'b0;
      step       = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               load       = 1'b1;
               state_next = (amt != '0) ? SHIFT : DONE;
            end
         end
         SHIFT: begin
            step = 1'b1;
            if (count == N'(1))
               state_next = DONE;
         end
         DONE: begin
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   assign busy      = (state != IDLE);
   assign done      = (state == DONE);
   assign state_dbg = state;

endmodule

// File: tb/tb_seq_lr_shifter.sv
// Directed bench for seq_lr_shifter: hand-computed results, latency, busy
// window, ignored start while busy, and reset abort.
module tb_seq_lr_shifter;

   localparam int N = 3;
   localparam int W = 8;

   logic         clk;
   logic         reset;
   logic         start;
   logic [W-1:0] a;
   logic [N-1:0] amt;
   logic         dir;
   logic         rot;
   logic         busy;
   logic         done;
   logic [W-1:0] y;
   logic [1:0]   state_dbg;

   int n_checks = 0;
   int n_fail   = 0;

   seq_lr_shifter #(.N(N)) dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .a         (a),
      .amt       (amt),
      .dir       (dir),
      .rot       (rot),
      .busy      (busy),
      .done      (done),
      .y         (y),
      .state_dbg (state_dbg)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic drive_start(input logic [W-1:0] a_v, input logic [N-1:0] amt_v,
                              input logic dir_v, input logic rot_v);
      start = 1'b1;
      a     = a_v;
      amt   = amt_v;
      dir   = dir_v;
      rot   = rot_v;
      tick();
      start = 1'b0;
      a     = $urandom_range(0, 255);
      amt   = N'($urandom_range(0, 7));
      dir   = 1'($urandom_range(0, 1));
      rot   = 1'($urandom_range(0, 1));
   endtask

   // Waits for done (bounded), checks latency, busy window and result,
   // then checks the return to IDLE.
   task automatic run_job(input string tag, input logic [W-1:0] a_v, input logic [N-1:0] amt_v,
                          input logic dir_v, input logic rot_v, input logic [W-1:0] exp_y);
      int lat;
      int busy_cycles;
      drive_start(a_v, amt_v, dir_v, rot_v);
      lat         = 1;
      busy_cycles = 0;
      while (done !== 1'b1 && lat < 20) begin
         if (busy === 1'b1) busy_cycles++;
         tick();
         lat++;
      end
      if (busy === 1'b1) busy_cycles++;
      check({tag, "_latency"}, lat, int'(amt_v) + 1);
      check({tag, "_busy_cycles"}, busy_cycles, int'(amt_v) + 1);
      check({tag, "_y"}, y, exp_y);
      check({tag, "_state_done"}, state_dbg, 2'd2);
      tick();
      check({tag, "_done_cleared"}, done, 1'b0);
      check({tag, "_idle"}, busy, 1'b0);
      check({tag, "_y_hold"}, y, exp_y);
   endtask

   initial begin
      int done_pulses;
      int lat;
      reset = 1'b1;
      start = 1'b0;
      a     = '0;
      amt   = '0;
      dir   = 1'b0;
      rot   = 1'b0;
      // reset held while start is asserted: reset must win
      tick();
      start = 1'b1;
      a     = 8'hA5;
      amt   = 3'd2;
      tick();
      start = 1'b0;
      check("reset_busy", busy, 1'b0);
      check("reset_done", done, 1'b0);
      check("reset_y", y, 8'h00);
      check("reset_state", state_dbg, 2'd0);
      reset = 1'b0;
      tick();
      check("idle_no_start", busy, 1'b0);

      run_job("t1_rl", 8'b10110011, 3'd1, 1'b0, 1'b0, 8'b01011001);
      run_job("t2_ll", 8'b10110011, 3'd3, 1'b1, 1'b0, 8'b10011000);
      run_job("t3_lr", 8'b10110011, 3'd5, 1'b1, 1'b1, 8'b01110110);
      run_job("t3_rr", 8'b11001100, 3'd4, 1'b0, 1'b1, 8'b11001100);
      run_job("t4_amt0", 8'b11110000, 3'd0, 1'b0, 1'b0, 8'b11110000);
      run_job("ll_max", 8'h81, 3'd7, 1'b1, 1'b0, 8'h80);
      run_job("rr_one", 8'h01, 3'd1, 1'b0, 1'b1, 8'h80);
      run_job("lr_max", 8'h81, 3'd7, 1'b1, 1'b1, 8'hC0);

      // t5: second start at T+3 must be ignored
      drive_start(8'hFF, 3'd7, 1'b0, 1'b0);
      done_pulses = 0;
      tick();
      start = 1'b1;
      a     = 8'h01;
      amt   = 3'd1;
      dir   = 1'b1;
      rot   = 1'b1;
      tick();
      start = 1'b0;
      lat = 3;
      while (done !== 1'b1 && lat < 20) begin
         tick();
         lat++;
      end
      check("t5_latency", lat, 8);
      check("t5_y", y, 8'h01);
      for (int i = 0; i < 12; i++) begin
         if (done === 1'b1) done_pulses++;
         tick();
      end
      check("t5_done_pulses", done_pulses, 1);
      check("t5_y_hold", y, 8'h01);

      // t6: reset at T+2 of an amt=6 job aborts with no done pulse
      drive_start(8'h3C, 3'd6, 1'b1, 1'b0);
      done_pulses = 0;
      if (done === 1'b1) done_pulses++;
      tick();
      if (done === 1'b1) done_pulses++;
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check("t6_busy", busy, 1'b0);
      check("t6_done", done, 1'b0);
      check("t6_y", y, 8'h00);
      check("t6_no_done_pulse", done_pulses, 0);
      run_job("t6_restart", 8'h96, 3'd2, 1'b0, 1'b0, 8'h25);

      $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
      $finish;
   end

endmodule
